// File: rtl/conv_out_addr_ctrl_if.sv
// conv_out_addr_ctrl_if: layer handshake, MAC beat input and feature-map address/write outputs
// of the convolution output-address controller.
interface conv_out_addr_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 2
) ();
    logic              start;
    logic              mac_valid;
    logic              busy;
    logic              neuron_rdy;
    logic              plane_rdy;
    logic              layer_done;
    logic [ADDR_W-1:0] out_addr;
    logic [SEL_W-1:0]  out_sel;
    logic              write_rdy;
    logic [ADDR_W-1:0] wr_addr;
    logic [SEL_W-1:0]  wr_sel;

    modport slave (
        input  start, mac_valid,
        output busy, neuron_rdy, plane_rdy, layer_done, out_addr, out_sel, write_rdy, wr_addr, wr_sel
    );

    modport master (
        output start, mac_valid,
        input  busy, neuron_rdy, plane_rdy, layer_done, out_addr, out_sel, write_rdy, wr_addr, wr_sel
    );
endinterface

// File: rtl/conv_out_addr_ctrl.sv
// conv_out_addr_ctrl: counts MAC beats per neuron, walks pixel/channel counters to build the packed
// feature-map address and lane, and delays them WR_DELAY cycles to line up with the RAM write port.
module conv_out_addr_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 8,
    parameter int KERNEL_BEATS = 25,
    parameter int PLANE_PIX    = 196,
    parameter int OUT_CH       = 8,
    parameter int CH_PACK      = 4,
    parameter int SEL_W        = 2,
    parameter int WR_DELAY     = 2
) (
    input logic clk,
    input logic rst_n,
    conv_out_addr_ctrl_if.slave bus
);
    localparam int CH_W = $clog2(OUT_CH + 1);
    localparam int DW   = $clog2(WR_DELAY + 1);

    if (KERNEL_BEATS < 1 || KERNEL_BEATS > (1 << CNT_W) || PLANE_PIX < 1 || OUT_CH < 1 || WR_DELAY < 1 ||
        CH_PACK < 1 || (CH_PACK & (CH_PACK - 1)) != 0 || (1 << SEL_W) < CH_PACK ||
        longint'((OUT_CH + CH_PACK - 1) / CH_PACK) * longint'(PLANE_PIX) > (64'd1 << ADDR_W)) begin : g_bad_cfg
        $error("conv_out_addr_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] pix_cnt, base;
    logic [CH_W-1:0]   ch_cnt;
    logic [SEL_W-1:0]  lane;
    logic [DW-1:0]     drain_cnt;
    logic              fin;
    logic              acc, done_beat, pix_last, ch_last, lane_last;
    logic              neuron_rdy, plane_rdy;
    logic [ADDR_W-1:0] out_addr;
    logic [SEL_W-1:0]  out_sel;
    logic              rdy_pipe  [WR_DELAY];
    logic [ADDR_W-1:0] addr_pipe [WR_DELAY];
    logic [SEL_W-1:0]  sel_pipe  [WR_DELAY];

    // fin marks the final neuron of the layer; beats after it are not counted while RUN hands over to DRAIN
    always_comb begin
        acc       = state == RUN && bus.mac_valid && !fin;
        done_beat = acc && beat_cnt == CNT_W'(KERNEL_BEATS - 1);
        pix_last  = pix_cnt == ADDR_W'(PLANE_PIX - 1);
        ch_last   = ch_cnt == CH_W'(OUT_CH - 1);
        lane_last = lane == SEL_W'(CH_PACK - 1);
        state_nx  = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = fin ? DRAIN : RUN;
            DRAIN:   state_nx = drain_cnt == DW'(WR_DELAY - 1) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            pix_cnt    <= '0;
            base       <= '0;
            ch_cnt     <= '0;
            lane       <= '0;
            drain_cnt  <= '0;
            fin        <= 1'b0;
            neuron_rdy <= 1'b0;
            plane_rdy  <= 1'b0;
            out_addr   <= '0;
            out_sel    <= '0;
        end else begin
            state      <= state_nx;
            neuron_rdy <= done_beat;
            plane_rdy  <= done_beat && pix_last;
            drain_cnt  <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            if (state == IDLE && bus.start) begin
                beat_cnt <= '0;
                pix_cnt  <= '0;
                base     <= '0;
                ch_cnt   <= '0;
                lane     <= '0;
                fin      <= 1'b0;
            end else if (acc) begin
                beat_cnt <= done_beat ? '0 : beat_cnt + 1'b1;
                if (done_beat) begin
                    out_addr <= base + pix_cnt;
                    out_sel  <= lane;
                    fin      <= pix_last && ch_last;
                    pix_cnt  <= pix_last ? '0 : pix_cnt + 1'b1;
                    if (pix_last) begin
                        ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
                        lane   <= (ch_last || lane_last) ? '0 : lane + 1'b1;
                        base   <= ch_last ? '0 : lane_last ? base + ADDR_W'(PLANE_PIX) : base;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_DELAY; i++) begin
                rdy_pipe[i]  <= 1'b0;
                addr_pipe[i] <= '0;
                sel_pipe[i]  <= '0;
            end
        end else begin
            rdy_pipe[0]  <= neuron_rdy;
            addr_pipe[0] <= out_addr;
            sel_pipe[0]  <= out_sel;
            for (int i = 1; i < WR_DELAY; i++) begin
                rdy_pipe[i]  <= rdy_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                sel_pipe[i]  <= sel_pipe[i-1];
            end
        end
    end

    assign bus.busy       = state != IDLE;
    assign bus.layer_done = state == DONE;
    assign bus.neuron_rdy = neuron_rdy;
    assign bus.plane_rdy  = plane_rdy;
    assign bus.out_addr   = out_addr;
    assign bus.out_sel    = out_sel;
    assign bus.write_rdy  = rdy_pipe[WR_DELAY-1];
    assign bus.wr_addr    = addr_pipe[WR_DELAY-1];
    assign bus.wr_sel     = sel_pipe[WR_DELAY-1];
endmodule
